// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: W-bit adder {co,sum} = a + b + ci computed CHUNK bits per clock over
// N = W/CHUNK cycles, with valid/ready handshakes on the operand and result sides.
// Optional feature macro: OVERFLOW_FLAG_EN adds the ovf output (signed overflow of the add).
module multi_cycle_adder #(
  parameter int unsigned W     = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] sum,
  output logic         co
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned N    = W / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // A partial final slice would silently truncate the operands, so refuse to elaborate.
  if ((W % CHUNK) != 0) begin : g_chunk_check
    $error("multi_cycle_adder: W (%0d) must be a multiple of CHUNK (%0d)", W, CHUNK);
  end

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            co_q, co_d;
`ifdef OVERFLOW_FLAG_EN
  logic            ovf_q, ovf_d;
  logic            carry_into_msb;
`endif

  logic [CHUNK-1:0] a_slice, b_slice, res_slice;
  logic             carry_out;
  logic             last_slice;

  // Select the operand slice addressed by the current slice index.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IdxW'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // One CHUNK-wide ripple step; the carry register chains the slices together.
  assign {carry_out, res_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};

  assign last_slice = (idx_q == LastIdx);

`ifdef OVERFLOW_FLAG_EN
  // Result MSB = a ^ b ^ carry-in, so the carry into bit W-1 falls out of the top slice bits.
  assign carry_into_msb = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ res_slice[CHUNK-1];
`endif

  // Next-state logic: accept in IDLE, one slice per cycle in BUSY, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    co_d    = co_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[i*CHUNK +: CHUNK] = res_slice;
          end
        end
        carry_d = carry_out;
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          co_d    = carry_out;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = carry_into_msb ^ carry_out;
`endif
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (m_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset also discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs; s_ready is masked by rst so nothing is offered as accepted during reset.
  always_comb begin
    s_ready = (state_q == StIdle) && !rst;
    m_valid = (state_q == StDone);
    sum     = sum_q;
    co      = co_q;
`ifdef OVERFLOW_FLAG_EN
    ovf     = ovf_q;
`endif
  end

`ifndef SYNTHESIS
  // Input and output sides never handshake in the same cycle.
  a_no_overlap : assert property (@(posedge clk) !(s_ready && m_valid));

  // A stalled result is held stable until it is taken.
  a_result_hold : assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(sum) && $stable(co)));

  // A taken result never lingers into the next cycle.
  a_result_drop : assert property (@(posedge clk) disable iff (rst)
    (m_valid && m_ready) |=> !m_valid);
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: directed scenarios on a CHUNK=8 instance plus randomized
// handshake traffic on CHUNK=1, 4, 32 and 8 instances, checked against plain arithmetic.
module tb_multi_cycle_adder;

  localparam int unsigned W    = 32;
  localparam int          NDut = 4;
  localparam longint      SMax = 64'sd2147483647;
  localparam longint      SMin = -SMax - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid [NDut];
  logic         s_ready [NDut];
  logic [W-1:0] a       [NDut];
  logic [W-1:0] b       [NDut];
  logic         ci      [NDut];
  logic         m_valid [NDut];
  logic         m_ready [NDut];
  logic [W-1:0] sum     [NDut];
  logic         co      [NDut];
`ifdef OVERFLOW_FLAG_EN
  logic         ovf     [NDut];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned Chunk = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    multi_cycle_adder #(
      .W    (W),
      .CHUNK(Chunk)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .s_valid(s_valid[g]),
      .s_ready(s_ready[g]),
      .a      (a[g]),
      .b      (b[g]),
      .ci     (ci[g]),
      .m_valid(m_valid[g]),
      .m_ready(m_ready[g]),
      .sum    (sum[g]),
      .co     (co[g])
`ifdef OVERFLOW_FLAG_EN
      ,
      .ovf    (ovf[g])
`endif
    );
  end

  function automatic int chunk_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 1 : (k == 2) ? 4 : 32;
  endfunction

  // Present operands on DUT 0 at the falling edge; s_valid stays high until accept0.
  task automatic drive0(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    a[0]       = av;
    b[0]       = bv;
    ci[0]      = cv;
    s_valid[0] = 1'b1;
    #1;
  endtask

  task automatic accept0();
    @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    a[0]       = $urandom();
    b[0]       = $urandom();
    ci[0]      = 1'($urandom_range(1));
  endtask

  // Count rising edges until m_valid on DUT 0; -1 when the bound expires.
  task automatic wait_valid0(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (m_valid[0] === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release0();
    @(negedge clk);
    m_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    m_ready[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (s_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_sready_low: got=%b want=0", s_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < NDut; k++) begin
      total++;
      if ({s_ready[k], m_valid[k], co[k], sum[k]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL reset_state chunk=%0d: got s_ready=%b m_valid=%b co=%b sum=%h want 1 0 0 0",
                 chunk_of(k), s_ready[k], m_valid[k], co[k], sum[k]);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    drive0(32'h0000_0001, 32'h0000_0002, 1'b0);
    total++;
    if (s_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_sready: got=%b want=1", s_ready[0]);
    end
    accept0();
    total++;
    if (s_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_sready: got=%b want=0", s_ready[0]);
    end
    wait_valid0(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL basic_latency: got=%0d want=4", lat);
    end
    total++;
    if ({co[0], sum[0]} !== {1'b0, 32'h0000_0003}) begin
      bad++;
      $display("FAIL basic_result: got co=%b sum=%h want co=0 sum=00000003", co[0], sum[0]);
    end
    release0();
    total++;
    if ({m_valid[0], s_ready[0]} !== 2'b01) begin
      bad++;
      $display("FAIL basic_release: got m_valid=%b s_ready=%b want 0 1", m_valid[0], s_ready[0]);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    drive0(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    accept0();
    wait_valid0(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL carry_latency: got=%0d want=4", lat);
    end
    total++;
    if ({co[0], sum[0]} !== {1'b1, 32'h0000_0000}) begin
      bad++;
      $display("FAIL carry_result: got co=%b sum=%h want co=1 sum=00000000", co[0], sum[0]);
    end
    release0();
  endtask

  // Previous op left co=1; a reset two slices into a new op must clear everything.
  task automatic test_reset_mid();
    int lat;
    drive0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    accept0();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (s_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_sready_in_rst: got=%b want=0", s_ready[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if ({m_valid[0], co[0], sum[0]} !== {1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL rstmid_cleared: got m_valid=%b co=%b sum=%h want 0 0 0",
               m_valid[0], co[0], sum[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (s_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_sready: got=%b want=1", s_ready[0]);
    end
    drive0(32'h1234_5678, 32'h1111_1111, 1'b0);
    accept0();
    wait_valid0(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL rstmid_latency: got=%0d want=4", lat);
    end
    total++;
    if ({co[0], sum[0]} !== {1'b0, 32'h2345_6789}) begin
      bad++;
      $display("FAIL rstmid_result: got co=%b sum=%h want co=0 sum=23456789", co[0], sum[0]);
    end
    release0();
  endtask

  task automatic test_backpressure();
    int lat;
    bit spurious;
    drive0(32'h0000_0010, 32'h0000_0020, 1'b1);
    accept0();
    wait_valid0(lat);
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL bp_latency: got=%0d want=4", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_valid[0] = 1'b1;
      a[0]       = $urandom();
      b[0]       = $urandom();
      ci[0]      = 1'b1;
      m_ready[0] = 1'b0;
      #1;
      total++;
      if (s_ready[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_sready cycle=%0d: got=%b want=0", c, s_ready[0]);
      end
      @(posedge clk);
      #1;
      total++;
      if ({m_valid[0], co[0], sum[0]} !== {1'b1, 1'b0, 32'h0000_0031}) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d: got m_valid=%b co=%b sum=%h want 1 0 00000031",
                 c, m_valid[0], co[0], sum[0]);
      end
    end
    @(negedge clk);
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    m_ready[0] = 1'b0;
    total++;
    if ({m_valid[0], s_ready[0]} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release: got m_valid=%b s_ready=%b want 0 1", m_valid[0], s_ready[0]);
    end
    spurious = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (m_valid[0] !== 1'b0) spurious = 1'b1;
    end
    total++;
    if (spurious) begin
      bad++;
      $display("FAIL bp_ignored_operands: got a result after release, want none");
    end
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_overflow();
    int lat;
    drive0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    accept0();
    wait_valid0(lat);
    total++;
    if ({ovf[0], co[0], sum[0]} !== {1'b1, 1'b0, 32'h8000_0000}) begin
      bad++;
      $display("FAIL ovf_pos: got ovf=%b co=%b sum=%h want 1 0 80000000", ovf[0], co[0], sum[0]);
    end
    release0();
    drive0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    accept0();
    wait_valid0(lat);
    total++;
    if ({ovf[0], co[0], sum[0]} !== {1'b0, 1'b1, 32'hFFFF_FFFE}) begin
      bad++;
      $display("FAIL ovf_neg: got ovf=%b co=%b sum=%h want 0 1 fffffffe", ovf[0], co[0], sum[0]);
    end
    release0();
  endtask
`endif

  // Random valid/ready traffic; every accepted operand set must come back once, in order.
  task automatic test_random(input int k, input int nops);
    logic [W:0] expq[$];
    logic       ovfq[$];
    logic [W:0] e;
    logic       eo;
    longint     sr;
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    while ((sent < nops || got < sent) && cyc < nops * 60 + 200) begin
      @(negedge clk);
      cyc++;
      s_valid[k] = (sent < nops) && ($urandom_range(3) != 0);
      a[k]       = $urandom();
      b[k]       = $urandom();
      ci[k]      = 1'($urandom_range(1));
      m_ready[k] = (sent >= nops) || ($urandom_range(2) != 0);
      #1;
      if (s_valid[k] && s_ready[k]) begin
        expq.push_back({1'b0, a[k]} + {1'b0, b[k]} + {32'h0, ci[k]});
        sr = longint'($signed(a[k])) + longint'($signed(b[k])) + longint'(ci[k]);
        ovfq.push_back((sr > SMax) || (sr < SMin));
        sent++;
      end
      if (m_valid[k] && m_ready[k]) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL rand_extra chunk=%0d: got co=%b sum=%h want no result",
                   chunk_of(k), co[k], sum[k]);
        end else begin
          e  = expq.pop_front();
          eo = ovfq.pop_front();
          got++;
          if ({co[k], sum[k]} !== e) begin
            bad++;
            $display("FAIL rand_result chunk=%0d n=%0d: got %h want %h",
                     chunk_of(k), got, {co[k], sum[k]}, e);
          end
`ifdef OVERFLOW_FLAG_EN
          total++;
          if (ovf[k] !== eo) begin
            bad++;
            $display("FAIL rand_ovf chunk=%0d n=%0d: got %b want %b", chunk_of(k), got, ovf[k], eo);
          end
`endif
        end
      end
    end
    @(negedge clk);
    s_valid[k] = 1'b0;
    m_ready[k] = 1'b0;
    total++;
    if (got != nops) begin
      bad++;
      $display("FAIL rand_count chunk=%0d: got %0d results want %0d", chunk_of(k), got, nops);
    end
  endtask

  initial begin
    for (int k = 0; k < NDut; k++) begin
      s_valid[k] = 1'b0;
      m_ready[k] = 1'b0;
      a[k]       = '0;
      b[k]       = '0;
      ci[k]      = 1'b0;
    end
    test_reset();
    test_basic();
    test_carry_chain();
    test_reset_mid();
    test_backpressure();
`ifdef OVERFLOW_FLAG_EN
    test_overflow();
`endif
    test_random(1, 350);
    test_random(2, 350);
    test_random(3, 350);
    test_random(0, 150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
